// File: rtl/mem_stage_gen_if.sv
// mem_stage_gen_if: EX-side, memory-side and WB-side signals of the MEM stage.
// The slave modport is the stage itself; the master modport is its
// environment (EX/MEM register, data memory and MEM/WB consumer).
// fsm_state is a debug view of the stage FSM: 0 = IDLE, 1 = RMW_WR.
// With MEM_STAGE_MISALIGN_TRAP_EN defined the misalign output exists.
interface mem_stage_gen_if #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int RW = 5
);
    logic          ex_valid;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic [1:0]    ex_size;
    logic          ex_unsigned;
    logic [AW-1:0] ex_addr;
    logic [DW-1:0] ex_wdata;
    logic          ex_memtoreg;
    logic          ex_regwrite;
    logic [RW-1:0] ex_rd;
    logic          ex_branch;
    logic          init_delay;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          stall;
    logic [DW-1:0] fwd_data;
    logic          wb_valid;
    logic          wb_memtoreg;
    logic          wb_regwrite;
    logic [DW-1:0] wb_rdata;
    logic [AW-1:0] wb_result;
    logic [RW-1:0] wb_rd;
    logic          branch_shadow;
    logic          fsm_state;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic          misalign;
`endif

    modport master (
        output ex_valid, ex_mem_read, ex_mem_write, ex_size, ex_unsigned,
               ex_addr, ex_wdata, ex_memtoreg, ex_regwrite, ex_rd, ex_branch,
               init_delay, mem_rdata, mem_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, stall, fwd_data,
               wb_valid, wb_memtoreg, wb_regwrite, wb_rdata, wb_result, wb_rd,
               branch_shadow, fsm_state
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
               , misalign
`endif
    );

    modport slave (
        input  ex_valid, ex_mem_read, ex_mem_write, ex_size, ex_unsigned,
               ex_addr, ex_wdata, ex_memtoreg, ex_regwrite, ex_rd, ex_branch,
               init_delay, mem_rdata, mem_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, stall, fwd_data,
               wb_valid, wb_memtoreg, wb_regwrite, wb_rdata, wb_result, wb_rd,
               branch_shadow, fsm_state
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
               , misalign
`endif
    );
endinterface

// File: rtl/mem_stage_gen.sv
// mem_stage_gen: DLX MEM stage. Drives a variable-latency data memory,
// extracts/extends sub-word loads, performs sub-word stores by
// read-modify-write, stalls upstream while an access is outstanding and
// squashes memory/register writes inside a branch shadow.
// Byte lanes are big-endian: offset 0 selects bits [DW-1:DW-8].
// Optional feature macro: MEM_STAGE_MISALIGN_TRAP_EN (misaligned half/word
// accesses are not issued and are flagged on the misalign output).
//
// Handshake: mem_req is held high (with stable address/data/we) until the
// memory returns mem_ack=1 in the same cycle; that cycle completes the
// access. mem_ack seen while mem_req=0 has no effect. stall=1 tells the
// EX/MEM register to hold its contents, which the stage relies on.
module mem_stage_gen #(
    parameter int DW     = 32,
    parameter int AW     = 32,
    parameter int RW     = 5,
    parameter int SHADOW = 3
) (
    input  logic           clk,
    input  logic           reset,
    mem_stage_gen_if.slave bus
);
    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);
    localparam logic [3:0]    SHADOW_CNT = 4'(SHADOW);
    localparam logic [DW-1:0] BYTE_TOP   = {8'hFF, {(DW-8){1'b0}}};
    localparam logic [DW-1:0] HALF_TOP   = {16'hFFFF, {(DW-16){1'b0}}};

    typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

    state_t        state;
    logic [3:0]    shadow_cnt;
    logic [DW-1:0] merge_q;

    logic [OW-1:0] offset;
    logic [OW+2:0] byte_sh;
    logic [OW+2:0] half_sh;
    logic          is_byte, is_half, is_word;
    logic          access, squash, trap_hit, memop, substore, word_store;
    logic          rmw, done, stall_int;
    logic [DW-1:0] byte_al, half_al, lane_mask, lane_data, merged;

    assign offset  = bus.ex_addr[OW-1:0];
    assign byte_sh = {offset, 3'b000};
    // Halfword lane ignores address bit 0.
    assign half_sh = {offset[OW-1:1], 4'b0000};
    assign is_byte = (bus.ex_size == 2'b00);
    assign is_half = (bus.ex_size == 2'b01);
    assign is_word = bus.ex_size[1];

    assign access     = bus.ex_valid & (bus.ex_mem_read | bus.ex_mem_write);
    assign squash     = bus.branch_shadow;
    assign substore   = bus.ex_mem_write & ~is_word;
    assign word_store = bus.ex_mem_write & is_word;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign trap_hit = access & ((is_half & offset[0]) | (is_word & (offset != '0)));
`else
    assign trap_hit = 1'b0;
`endif

    assign memop = access & ~squash & ~trap_hit;
    assign rmw   = (state == RMW_WR);

    // Memory request side: combinational from EX inputs and state, gated by reset.
    assign bus.mem_req  = ~reset & (memop | rmw);
    assign bus.mem_we   = ~reset & (rmw | (memop & word_store));
    assign bus.mem_addr = {bus.ex_addr[AW-1:OW], {OW{1'b0}}};

    // Sub-word store: overlay the right-justified store data onto the captured word.
    assign lane_mask = is_byte ? (BYTE_TOP >> byte_sh) : (HALF_TOP >> half_sh);
    assign lane_data = is_byte ? ({bus.ex_wdata[7:0], {(DW-8){1'b0}}} >> byte_sh)
                               : ({bus.ex_wdata[15:0], {(DW-16){1'b0}}} >> half_sh);
    assign merged        = (merge_q & ~lane_mask) | (lane_data & lane_mask);
    assign bus.mem_wdata = word_store ? bus.ex_wdata : merged;

    assign done      = bus.mem_ack & bus.mem_req & (rmw | ~substore);
    assign stall_int = ~reset & (memop | rmw) & ~done;
    assign bus.stall = stall_int;

    assign byte_al = bus.mem_rdata << byte_sh;
    assign half_al = bus.mem_rdata << half_sh;

    // Load alignment: move the selected lane to the top, then extend to DW.
    always_comb begin
        bus.fwd_data = bus.mem_rdata;
        if (is_byte) begin
            bus.fwd_data = {{(DW-8){~bus.ex_unsigned & byte_al[DW-1]}}, byte_al[DW-1 -: 8]};
        end else if (is_half) begin
            bus.fwd_data = {{(DW-16){~bus.ex_unsigned & half_al[DW-1]}}, half_al[DW-1 -: 16]};
        end
    end

    assign bus.branch_shadow = (shadow_cnt != 4'd0) & ~bus.init_delay;
    assign bus.fsm_state     = rmw;

    // Read-modify-write FSM: capture the old word, then write the merged word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            merge_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memop & substore & bus.mem_ack) begin
                        merge_q <= bus.mem_rdata;
                        state   <= RMW_WR;
                    end
                end
                RMW_WR: begin
                    if (bus.mem_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Branch-shadow counter: reload on an accepted branch, otherwise run down to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_cnt <= 4'd0;
        end else if (bus.ex_branch & ~stall_int) begin
            shadow_cnt <= SHADOW_CNT;
        end else if (shadow_cnt != 4'd0) begin
            shadow_cnt <= shadow_cnt - 4'd1;
        end
    end

    // MEM/WB register: advances on every non-stalled cycle, holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.wb_valid    <= 1'b0;
            bus.wb_memtoreg <= 1'b0;
            bus.wb_regwrite <= 1'b0;
            bus.wb_rdata    <= '0;
            bus.wb_result   <= '0;
            bus.wb_rd       <= '0;
        end else if (~stall_int) begin
            bus.wb_valid    <= bus.ex_valid & ~squash;
            bus.wb_memtoreg <= bus.ex_memtoreg;
            bus.wb_regwrite <= bus.ex_regwrite & ~squash & ~trap_hit;
            bus.wb_rdata    <= bus.fwd_data;
            bus.wb_result   <= bus.ex_addr;
            bus.wb_rd       <= bus.ex_rd;
        end
    end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    // Misalign flag travels with the trapped instruction into WB.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.misalign <= 1'b0;
        end else if (~stall_int) begin
            bus.misalign <= trap_hit & ~squash;
        end
    end
`endif
endmodule

// File: tb/tb_mem_stage_gen.sv
// tb_mem_stage_gen: directed and random checks of mem_stage_gen (DW=32,
// SHADOW=3) against a byte-level memory model and a cycle-index branch
// shadow model. Honours MEM_STAGE_MISALIGN_TRAP_EN when defined.
module tb_mem_stage_gen;
    localparam int SHADOW = 3;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;
    int   last_br = -100;
    logic [4:0]  prev_rd;
    logic [31:0] prev_result;
    logic [31:0] ref_mem [128];
    logic [31:0] dev_mem [128];

    mem_stage_gen_if #(.DW(32), .AW(32), .RW(5)) bus ();

    mem_stage_gen #(.DW(32), .AW(32), .RW(5), .SHADOW(SHADOW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and cycle index
    always #5 clk = ~clk;
    always @(posedge clk) cyc_no <= cyc_no + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference load: pick big-endian byte/half of the stored word, extend.
    function automatic logic [31:0] ref_load(logic [31:0] word, logic [1:0] sz, bit uns,
                                             logic [31:0] addr);
        logic [31:0] v;
        int sh;
        if (sz == 2'b00) begin
            sh = 8 * (3 - int'(addr[1:0]));
            v = (word >> sh) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            sh = 16 * (1 - int'(addr[1]));
            v = (word >> sh) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    // Reference store: replace the addressed byte/half of the old word.
    function automatic logic [31:0] ref_store(logic [31:0] old, logic [1:0] sz,
                                              logic [31:0] addr, logic [31:0] wd);
        int sh;
        if (sz == 2'b00) begin
            sh = 8 * (3 - int'(addr[1:0]));
            return (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        end else if (sz == 2'b01) begin
            sh = 16 * (1 - int'(addr[1]));
            return (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
        end
        return wd;
    endfunction

    task automatic drive_idle();
        bus.ex_valid = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_mem_write = 1'b0;
        bus.ex_size = 2'b10; bus.ex_unsigned = 1'b0; bus.ex_addr = 32'h0;
        bus.ex_wdata = 32'h0; bus.ex_memtoreg = 1'b0; bus.ex_regwrite = 1'b0;
        bus.ex_rd = 5'd0; bus.ex_branch = 1'b0; bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
    endtask

    // Driver + memory responder for one instruction; checks against the model.
    task automatic do_op(input string tag, input bit rd, input bit wr, input logic [1:0] sz,
                         input bit uns, input logic [31:0] addr, input logic [31:0] wd,
                         input bit br, input int waits);
        bit sq, mis, memop, sub, rw, mtr, done;
        logic [4:0]  rdi;
        logic [31:0] exp_load, exp_word, last_wd;
        int d, idx, exp_stall, exp_req, stall_n, req_n, wr_n, ncyc, pend, done_p;
        idx = int'(addr[8:2]);
        rdi = 5'($urandom);
        mtr = 1'($urandom);
        rw  = rd ? 1'b1 : 1'($urandom);
        @(negedge clk);
        d  = cyc_no - last_br;
        sq = (d >= 1) && (d <= SHADOW) && !bus.init_delay;
        mis = 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        mis = (rd || wr) && ((sz == 2'b01 && addr[0]) || (sz[1] && addr[1:0] != 2'b00));
`endif
        memop = (rd || wr) && !sq && !mis;
        sub   = wr && !sz[1];
        exp_req   = !memop ? 0 : (sub ? 2 * (waits + 1) : waits + 1);
        exp_stall = !memop ? 0 : (sub ? 1 + 2 * waits : waits);
        exp_load  = ref_load(ref_mem[idx], sz, uns, addr);
        exp_word  = ref_store(ref_mem[idx], sz, addr, wd);
        if (memop && wr) ref_mem[idx] = exp_word;
        bus.ex_valid = 1'b1; bus.ex_mem_read = rd; bus.ex_mem_write = wr;
        bus.ex_size = sz; bus.ex_unsigned = uns; bus.ex_addr = addr; bus.ex_wdata = wd;
        bus.ex_memtoreg = mtr; bus.ex_regwrite = rw; bus.ex_rd = rdi; bus.ex_branch = br;
        stall_n = 0; req_n = 0; wr_n = 0; ncyc = 0; pend = 0; done = 1'b0; done_p = 0;
        last_wd = 32'h0;
        while (!done && ncyc < 40) begin
            #1;
            if (bus.mem_req) begin
                if (pend >= waits) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = dev_mem[bus.mem_addr[8:2]];
                end else begin
                    bus.mem_ack = 1'b0;
                    pend++;
                end
            end else begin
                bus.mem_ack = 1'b0;
            end
            #1;
            if (ncyc == 0) chk({tag, " branch_shadow"}, bus.branch_shadow, sq);
            if (bus.mem_req) req_n++;
            if (bus.stall) begin
                stall_n++;
                chk({tag, " hold wb_rd"}, bus.wb_rd, prev_rd);
                chk({tag, " hold wb_result"}, bus.wb_result, prev_result);
            end
            if (bus.mem_req && bus.mem_ack) begin
                pend = 0;
                if (bus.mem_we) begin
                    dev_mem[bus.mem_addr[8:2]] = bus.mem_wdata;
                    last_wd = bus.mem_wdata;
                    wr_n++;
                end
            end
            if (!bus.stall) begin
                done = 1'b1;
                done_p = cyc_no;
                if (memop && rd && !wr) chk({tag, " fwd_data"}, bus.fwd_data, exp_load);
            end
            @(posedge clk);
            ncyc++;
            if (!done) @(negedge clk);
        end
        #1;
        chk({tag, " completed"}, done, 1'b1);
        chk({tag, " cycles"}, ncyc, exp_stall + 1);
        chk({tag, " stall cycles"}, stall_n, exp_stall);
        chk({tag, " req cycles"}, req_n, exp_req);
        chk({tag, " writes"}, wr_n, (memop && wr) ? 1 : 0);
        if (memop && wr) begin
            chk({tag, " mem_wdata"}, last_wd, exp_word);
            chk({tag, " mem word"}, dev_mem[idx], ref_mem[idx]);
        end
        chk({tag, " wb_valid"}, bus.wb_valid, !sq);
        chk({tag, " wb_regwrite"}, bus.wb_regwrite, rw && !sq && !mis);
        chk({tag, " wb_rd"}, bus.wb_rd, rdi);
        chk({tag, " wb_memtoreg"}, bus.wb_memtoreg, mtr);
        chk({tag, " wb_result"}, bus.wb_result, addr);
        if (memop && rd && !wr) chk({tag, " wb_rdata"}, bus.wb_rdata, exp_load);
        chk({tag, " fsm idle"}, bus.fsm_state, 1'b0);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        chk({tag, " misalign"}, bus.misalign, mis && !sq);
`endif
        if (br && done) last_br = done_p;
        prev_rd = rdi;
        prev_result = addr;
    endtask

    initial begin
        int kind;
        logic [31:0] a;
        for (int i = 0; i < 128; i++) begin
            ref_mem[i] = $urandom;
            dev_mem[i] = ref_mem[i];
        end
        ref_mem[32'h100 >> 2] = 32'h1122_3344; dev_mem[32'h100 >> 2] = 32'h1122_3344;
        ref_mem[32'h104 >> 2] = 32'hF0A1_B2C3; dev_mem[32'h104 >> 2] = 32'hF0A1_B2C3;

        // Reset with an active load presented: no request, no stall, WB cleared
        reset = 1'b1;
        drive_idle();
        bus.init_delay = 1'b0;
        bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_addr = 32'h100;
        bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd9; bus.ex_branch = 1'b1; bus.mem_ack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset mem_req", bus.mem_req, 1'b0);
        chk("reset mem_we", bus.mem_we, 1'b0);
        chk("reset stall", bus.stall, 1'b0);
        chk("reset wb_valid", bus.wb_valid, 1'b0);
        chk("reset wb_regwrite", bus.wb_regwrite, 1'b0);
        chk("reset wb_rd", bus.wb_rd, 5'd0);
        chk("reset wb_rdata", bus.wb_rdata, 32'h0);
        chk("reset wb_result", bus.wb_result, 32'h0);
        chk("reset branch_shadow", bus.branch_shadow, 1'b0);
        chk("reset fsm", bus.fsm_state, 1'b0);
        reset = 1'b0;
        drive_idle();
        prev_rd = 5'd0; prev_result = 32'h0; last_br = -100;

        // Sub-word loads on a zero-wait memory
        do_op("lb_101", 1, 0, 2'b00, 0, 32'h101, 0, 0, 0);
        do_op("lb_100", 1, 0, 2'b00, 0, 32'h100, 0, 0, 0);
        do_op("lbu_104", 1, 0, 2'b00, 1, 32'h104, 0, 0, 0);
        do_op("lb_104", 1, 0, 2'b00, 0, 32'h104, 0, 0, 0);
        do_op("lh_102", 1, 0, 2'b01, 0, 32'h102, 0, 0, 0);
        do_op("lh_104", 1, 0, 2'b01, 0, 32'h104, 0, 0, 0);
        do_op("lhu_103", 1, 0, 2'b01, 1, 32'h103, 0, 0, 0);
        do_op("lw_100", 1, 0, 2'b10, 0, 32'h100, 0, 0, 0);
        do_op("lw_sz3_104", 1, 0, 2'b11, 0, 32'h104, 0, 0, 0);
        // Byte store by read-modify-write, then read back
        do_op("sb_102", 0, 1, 2'b00, 0, 32'h102, 32'h0000_00AB, 0, 0);
        do_op("lw_after_sb", 1, 0, 2'b10, 0, 32'h100, 0, 0, 0);
        do_op("sh_106", 0, 1, 2'b01, 0, 32'h106, 32'h1234_5678, 0, 1);
        do_op("sw_108", 0, 1, 2'b10, 0, 32'h108, 32'hDEAD_BEEF, 0, 2);
        // Slow memory: three wait cycles on a word load
        do_op("lw_wait3", 1, 0, 2'b10, 0, 32'h108, 0, 0, 3);
        // Misaligned word load (dropped low bits, or trapped)
        do_op("lw_102", 1, 0, 2'b10, 0, 32'h102, 0, 0, 0);

        // Branch shadow: three squashed stores, the fourth writes
        do_op("br_a", 0, 0, 2'b10, 0, 32'h0, 0, 1, 0);
        for (int i = 0; i < 4; i++)
            do_op("sw_shadow", 0, 1, 2'b10, 0, 32'h110 + 32'(4 * i), $urandom, 0, 0);
        // Same pattern with init_delay: nothing squashed
        bus.init_delay = 1'b1;
        do_op("br_b", 0, 0, 2'b10, 0, 32'h0, 0, 1, 0);
        for (int i = 0; i < 4; i++)
            do_op("sw_init", 0, 1, 2'b10, 0, 32'h120 + 32'(4 * i), $urandom, 0, 0);
        bus.init_delay = 1'b0;

        // Random mix
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            bus.init_delay = ($urandom_range(0, 9) == 0);
            a = 32'h100 + 32'($urandom_range(0, 63));
            if (kind < 2)
                do_op("rnd_alu", 0, 0, 2'($urandom), 1'($urandom), a, $urandom, kind == 0, 0);
            else if (kind < 6)
                do_op("rnd_ld", 1, 0, 2'($urandom), 1'($urandom), a, 0, 0, $urandom_range(0, 2));
            else
                do_op("rnd_st", 0, 1, 2'($urandom), 0, a, $urandom, 0, $urandom_range(0, 2));
        end
        bus.init_delay = 1'b0;
        for (int i = 0; i < 4; i++) do_op("drain", 0, 0, 2'b10, 0, 32'h0, 0, 0, 0);

        // Reset while in the write half of a read-modify-write
        @(negedge clk);
        bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b0; bus.ex_mem_write = 1'b1;
        bus.ex_size = 2'b00; bus.ex_addr = 32'h105; bus.ex_wdata = 32'h5A;
        bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd7; bus.ex_branch = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = dev_mem[32'h104 >> 2];
        #1;
        chk("rst_rmw read req", bus.mem_req, 1'b1);
        chk("rst_rmw read we", bus.mem_we, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_rmw in write", bus.fsm_state, 1'b1);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_rmw mem_req", bus.mem_req, 1'b0);
        chk("rst_rmw mem_we", bus.mem_we, 1'b0);
        chk("rst_rmw stall", bus.stall, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_rmw fsm", bus.fsm_state, 1'b0);
        chk("rst_rmw wb_valid", bus.wb_valid, 1'b0);
        chk("rst_rmw wb_regwrite", bus.wb_regwrite, 1'b0);
        chk("rst_rmw wb_rd", bus.wb_rd, 5'd0);
        chk("rst_rmw wb_result", bus.wb_result, 32'h0);
        chk("rst_rmw wb_rdata", bus.wb_rdata, 32'h0);
        chk("rst_rmw mem word", dev_mem[32'h104 >> 2], ref_mem[32'h104 >> 2]);
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        prev_rd = 5'd0; prev_result = 32'h0; last_br = -100;
        do_op("post_rst_lb", 1, 0, 2'b00, 0, 32'h105, 0, 0, 0);
        do_op("post_rst_sh", 0, 1, 2'b01, 0, 32'h10A, 32'h0000_CAFE, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
